// File: rtl/pipelined_sum_select.sv
// Two-stage valid/ready pipelined adder: sum2=a+b+c, sum1=sel ? a+b : a+b+c+d.
// Define PIPELINED_SUM_SAT_EN to clamp overflowing results to all ones.
module pipelined_sum_select #(
  parameter int WIDTH = 4,
  parameter int OUT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  input  logic [WIDTH-1:0] data_d,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out1,
  output logic [OUT_W-1:0] data_out2,
  output logic             ovf1,
  output logic             ovf2
);

  localparam int SW = WIDTH + 2;
  localparam int EW = (OUT_W > SW) ? OUT_W : SW;

  logic [WIDTH:0]  ab_q;
  logic [WIDTH:0]  cd_q;
  logic [WIDTH:0]  c_q;
  logic            sel_q;
  logic            v1_q;

  logic            s2_ready;
  logic            accept;
  logic            s1_move;
  logic [SW-1:0]   full;
  logic [SW-1:0]   abc;
  logic [SW-1:0]   sum1;
  logic [OUT_W:0]  fit1;
  logic [OUT_W:0]  fit2;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !v1_q || s2_ready;
  assign accept   = in_valid && in_ready;
  assign s1_move  = v1_q && s2_ready;

  assign full = SW'(ab_q) + SW'(cd_q);
  assign abc  = SW'(ab_q) + SW'(c_q);
  assign sum1 = sel_q ? SW'(ab_q) : full;

  // Returns {ovf, result} for a true sum; wraps or clamps per build.
  function automatic logic [OUT_W:0] fit(input logic [SW-1:0] s);
    logic [EW-1:0]    x;
    logic             o;
    logic [OUT_W-1:0] r;
    x = EW'(s);
    o = |(x >> OUT_W);
    r = x[OUT_W-1:0];
`ifdef PIPELINED_SUM_SAT_EN
    if (o) r = '1;
`endif
    return {o, r};
  endfunction

  assign fit1 = fit(sum1);
  assign fit2 = fit(abc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      ab_q  <= '0;
      cd_q  <= '0;
      c_q   <= '0;
      sel_q <= 1'b0;
    end else begin
      if (in_ready) v1_q <= in_valid;
      if (accept) begin
        ab_q  <= {1'b0, data_a} + {1'b0, data_b};
        cd_q  <= {1'b0, data_c} + {1'b0, data_d};
        c_q   <= {1'b0, data_c};
        sel_q <= sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out1 <= '0;
      data_out2 <= '0;
      ovf1      <= 1'b0;
      ovf2      <= 1'b0;
    end else begin
      if (s2_ready) out_valid <= v1_q;
      if (s1_move) begin
        data_out1 <= fit1[OUT_W-1:0];
        data_out2 <= fit2[OUT_W-1:0];
        ovf1      <= fit1[OUT_W];
        ovf2      <= fit2[OUT_W];
      end
    end
  end

endmodule
